// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - operand forwarding select and load-use stall unit with internal shadow pipeline
// Optional stall statistics counter enabled by defining HAZ_STATS_EN.
module fwd_hazard_unit #(
    parameter  int NUM_SRC    = 2,
    parameter  int DEPTH      = 2,
    parameter  int REG_AW     = 5,
    parameter  int LOAD_READY = 1,
    localparam int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      id_valid,
    input  logic [REG_AW-1:0]         id_rd,
    input  logic                      id_reg_wr,
    input  logic                      id_is_load,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs,
    input  logic [NUM_SRC-1:0]        id_rs_used,
    input  logic                      id_flush,
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
    output logic                      stall
`ifdef HAZ_STATS_EN
    ,
    output logic [31:0]               stall_count
`endif
);

    logic [DEPTH-1:0]             v_q,  v_d;
    logic [DEPTH-1:0][REG_AW-1:0] rd_q, rd_d;
    logic [DEPTH-1:0]             ld_q, ld_d;

    logic                         any_hazard;
    logic                         issue;

    // Scan oldest to youngest so the smallest matching index is the last write and wins.
    always_comb begin
        fwd_sel    = '0;
        any_hazard = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            logic [SEL_W-1:0]  sel_i;
            logic              haz_i;
            logic [REG_AW-1:0] rs_i;
            sel_i = '0;
            haz_i = 1'b0;
            rs_i  = id_rs[i*REG_AW +: REG_AW];
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (id_rs_used[i] && (rs_i != '0) && v_q[k] && (rd_q[k] == rs_i)) begin
                    sel_i = SEL_W'(k + 1);
                    haz_i = ld_q[k] && (k < LOAD_READY);
                end
            end
            fwd_sel[i*SEL_W +: SEL_W] = sel_i;
            any_hazard                = any_hazard | haz_i;
        end
    end

    assign stall = id_valid && !id_flush && any_hazard;
    assign issue = id_valid && !id_flush && !stall;

    always_comb begin
        v_d  = '0;
        rd_d = rd_q;
        ld_d = ld_q;
        v_d[0]  = issue && id_reg_wr && (id_rd != '0);
        rd_d[0] = id_rd;
        ld_d[0] = id_is_load;
        for (int k = 1; k < DEPTH; k++) begin
            v_d[k]  = v_q[k-1];
            rd_d[k] = rd_q[k-1];
            ld_d[k] = ld_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q  <= '0;
            rd_q <= '0;
            ld_q <= '0;
        end else begin
            v_q  <= v_d;
            rd_q <= rd_d;
            ld_q <= ld_d;
        end
    end

`ifdef HAZ_STATS_EN
    logic [31:0] stall_count_q, stall_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - scoreboard bench for fwd_hazard_unit (default and DEPTH=4/LOAD_READY=2 instances)
module tb_fwd_hazard_unit;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rd;
    logic       id_reg_wr;
    logic       id_is_load;
    logic [9:0] id_rs;
    logic [1:0] id_rs_used;
    logic       id_flush;

    logic [3:0] fwd_sel2;
    logic       stall2;
    logic [5:0] fwd_sel4;
    logic       stall4;
`ifdef HAZ_STATS_EN
    logic [31:0] cnt2;
    logic [31:0] cnt4;
`endif

    fwd_hazard_unit dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_rd      (id_rd),
        .id_reg_wr  (id_reg_wr),
        .id_is_load (id_is_load),
        .id_rs      (id_rs),
        .id_rs_used (id_rs_used),
        .id_flush   (id_flush),
        .fwd_sel    (fwd_sel2),
        .stall      (stall2)
`ifdef HAZ_STATS_EN
        ,
        .stall_count(cnt2)
`endif
    );

    fwd_hazard_unit #(.DEPTH(4), .LOAD_READY(2)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_rd      (id_rd),
        .id_reg_wr  (id_reg_wr),
        .id_is_load (id_is_load),
        .id_rs      (id_rs),
        .id_rs_used (id_rs_used),
        .id_flush   (id_flush),
        .fwd_sel    (fwd_sel4),
        .stall      (stall4)
`ifdef HAZ_STATS_EN
        ,
        .stall_count(cnt4)
`endif
    );

    typedef struct {
        logic       v;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
        logic [4:0] rs0;
        logic [4:0] rs1;
        logic [1:0] used;
        logic       fl;
        logic [7:0] sel;
        logic       st;
    } step_t;

    typedef struct {
        logic [7:0] sel;
        logic       st;
    } exp_t;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];

    function automatic step_t mk(input logic v, input logic [4:0] rd, input logic wr, input logic ld,
                                 input logic [4:0] rs0, input logic [4:0] rs1, input logic [1:0] used,
                                 input logic fl, input logic [7:0] sel, input logic st);
        step_t s;
        s.v = v; s.rd = rd; s.wr = wr; s.ld = ld; s.rs0 = rs0; s.rs1 = rs1;
        s.used = used; s.fl = fl; s.sel = sel; s.st = st;
        return s;
    endfunction

    task automatic apply(input step_t s);
        exp_t e;
        id_valid   = s.v;
        id_rd      = s.rd;
        id_reg_wr  = s.wr;
        id_is_load = s.ld;
        id_rs      = {s.rs1, s.rs0};
        id_rs_used = s.used;
        id_flush   = s.fl;
        e.sel = s.sel;
        e.st  = s.st;
        sb_q.push_back(e);
    endtask

    task automatic idle();
        id_valid = 0; id_rd = 0; id_reg_wr = 0; id_is_load = 0;
        id_rs = 0; id_rs_used = 0; id_flush = 0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        apply(mk(1, 5'd5, 1, 1, 5'd5, 5'd5, 2'b11, 0, 8'h00, 0));
        @(negedge clk);
        e = sb_q.pop_front();
        checks++;
        if ({4'b0, fwd_sel2, stall2} !== {e.sel, e.st}) begin
            failures++;
            $display("FAIL reset_out: sel=%h stall=%b expected sel=%h stall=%b", fwd_sel2, stall2, e.sel, e.st);
        end
        @(posedge clk); #1;
        apply(mk(1, 5'd6, 0, 0, 5'd5, 5'd5, 2'b11, 0, 8'h00, 0));
        @(negedge clk);
        e = sb_q.pop_front();
        checks++;
        if ({4'b0, fwd_sel2, stall2} !== {e.sel, e.st}) begin
            failures++;
            $display("FAIL reset_hold: sel=%h stall=%b expected sel=%h stall=%b", fwd_sel2, stall2, e.sel, e.st);
        end
`ifdef HAZ_STATS_EN
        checks++;
        if (cnt2 !== 32'd0) begin
            failures++;
            $display("FAIL reset_count: got %0d expected 0", cnt2);
        end
`endif
        @(posedge clk); #1;
        idle();
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        step_t s[$];
        exp_t  e;
        do_reset();
        s.push_back(mk(1, 5'd5, 1, 0, 5'd1, 5'd2, 2'b11, 0, 8'h00, 0));
        s.push_back(mk(1, 5'd6, 1, 0, 5'd5, 5'd5, 2'b11, 0, 8'h05, 0));
        foreach (s[j]) begin
            apply(s[j]);
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if ({4'b0, fwd_sel2, stall2} !== {e.sel, e.st}) begin
                failures++;
                $display("FAIL back_to_back step %0d: sel=%h stall=%b expected sel=%h stall=%b", j, fwd_sel2, stall2, e.sel, e.st);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_two_apart();
        step_t s[$];
        exp_t  e;
        do_reset();
        s.push_back(mk(1, 5'd7, 1, 0, 5'd0, 5'd0, 2'b00, 0, 8'h00, 0));
        s.push_back(mk(1, 5'd8, 1, 0, 5'd1, 5'd2, 2'b11, 0, 8'h00, 0));
        s.push_back(mk(1, 5'd9, 0, 0, 5'd3, 5'd7, 2'b11, 0, 8'h08, 0));
        s.push_back(mk(1, 5'd7, 1, 0, 5'd0, 5'd0, 2'b00, 0, 8'h00, 0));
        s.push_back(mk(1, 5'd1, 0, 0, 5'd0, 5'd0, 2'b00, 0, 8'h00, 0));
        s.push_back(mk(1, 5'd1, 0, 0, 5'd0, 5'd0, 2'b00, 0, 8'h00, 0));
        s.push_back(mk(1, 5'd1, 0, 0, 5'd0, 5'd7, 2'b10, 0, 8'h00, 0));
        foreach (s[j]) begin
            apply(s[j]);
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if ({4'b0, fwd_sel2, stall2} !== {e.sel, e.st}) begin
                failures++;
                $display("FAIL two_apart step %0d: sel=%h stall=%b expected sel=%h stall=%b", j, fwd_sel2, stall2, e.sel, e.st);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        step_t s[$];
        exp_t  e;
        do_reset();
        s.push_back(mk(1, 5'd9,  1, 1, 5'd0, 5'd0, 2'b00, 0, 8'h00, 0));
        s.push_back(mk(1, 5'd10, 1, 0, 5'd9, 5'd1, 2'b11, 0, 8'h01, 1));
        s.push_back(mk(1, 5'd10, 1, 0, 5'd9, 5'd1, 2'b11, 0, 8'h02, 0));
        foreach (s[j]) begin
            apply(s[j]);
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if ({4'b0, fwd_sel2, stall2} !== {e.sel, e.st}) begin
                failures++;
                $display("FAIL load_use step %0d: sel=%h stall=%b expected sel=%h stall=%b", j, fwd_sel2, stall2, e.sel, e.st);
            end
            @(posedge clk); #1;
        end
`ifdef HAZ_STATS_EN
        checks++;
        if (cnt2 !== 32'd1) begin
            failures++;
            $display("FAIL load_use_count: got %0d expected 1", cnt2);
        end
`endif
    endtask

    task automatic test_youngest_x0();
        step_t s[$];
        exp_t  e;
        do_reset();
        s.push_back(mk(1, 5'd3, 1, 0, 5'd0, 5'd0, 2'b00, 0, 8'h00, 0));
        s.push_back(mk(1, 5'd3, 1, 0, 5'd0, 5'd0, 2'b00, 0, 8'h00, 0));
        s.push_back(mk(1, 5'd0, 1, 1, 5'd3, 5'd3, 2'b01, 0, 8'h01, 0));
        s.push_back(mk(1, 5'd4, 0, 0, 5'd0, 5'd3, 2'b11, 0, 8'h08, 0));
        foreach (s[j]) begin
            apply(s[j]);
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if ({4'b0, fwd_sel2, stall2} !== {e.sel, e.st}) begin
                failures++;
                $display("FAIL youngest_x0 step %0d: sel=%h stall=%b expected sel=%h stall=%b", j, fwd_sel2, stall2, e.sel, e.st);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_flush();
        step_t s[$];
        exp_t  e;
        do_reset();
        s.push_back(mk(1, 5'd9,  1, 1, 5'd0,  5'd0, 2'b00, 0, 8'h00, 0));
        s.push_back(mk(1, 5'd10, 1, 0, 5'd9,  5'd1, 2'b11, 1, 8'h01, 0));
        s.push_back(mk(1, 5'd11, 0, 0, 5'd10, 5'd9, 2'b11, 0, 8'h08, 0));
        foreach (s[j]) begin
            apply(s[j]);
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if ({4'b0, fwd_sel2, stall2} !== {e.sel, e.st}) begin
                failures++;
                $display("FAIL flush step %0d: sel=%h stall=%b expected sel=%h stall=%b", j, fwd_sel2, stall2, e.sel, e.st);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_stall();
        step_t s[$];
        exp_t  e;
        do_reset();
        s.push_back(mk(1, 5'd9,  1, 1, 5'd0, 5'd0, 2'b00, 0, 8'h00, 0));
        s.push_back(mk(1, 5'd10, 1, 0, 5'd9, 5'd9, 2'b11, 0, 8'h05, 1));
        foreach (s[j]) begin
            apply(s[j]);
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if ({4'b0, fwd_sel2, stall2} !== {e.sel, e.st}) begin
                failures++;
                $display("FAIL mid_stall_pre step %0d: sel=%h stall=%b expected sel=%h stall=%b", j, fwd_sel2, stall2, e.sel, e.st);
            end
            if (j < s.size() - 1) begin
                @(posedge clk); #1;
            end
        end
        e.sel = 8'h00;
        e.st  = 1'b0;
        sb_q.push_back(e);
        rst_n = 1'b0;
        #1;
        e = sb_q.pop_front();
        checks++;
        if ({4'b0, fwd_sel2, stall2} !== {e.sel, e.st}) begin
            failures++;
            $display("FAIL mid_stall_reset: sel=%h stall=%b expected sel=%h stall=%b", fwd_sel2, stall2, e.sel, e.st);
        end
        @(posedge clk); #1;
        idle();
        rst_n = 1'b1;
    endtask

    task automatic test_param_sweep();
        step_t s[$];
        exp_t  e;
        do_reset();
        s.push_back(mk(1, 5'd9,  1, 1, 5'd0, 5'd0, 2'b00, 0, 8'h00, 0));
        s.push_back(mk(1, 5'd10, 0, 0, 5'd9, 5'd0, 2'b01, 0, 8'h01, 1));
        s.push_back(mk(1, 5'd10, 0, 0, 5'd9, 5'd0, 2'b01, 0, 8'h02, 1));
        s.push_back(mk(1, 5'd10, 0, 0, 5'd9, 5'd0, 2'b01, 0, 8'h03, 0));
        s.push_back(mk(0, 5'd0,  0, 0, 5'd0, 5'd0, 2'b00, 0, 8'h00, 0));
        foreach (s[j]) begin
            apply(s[j]);
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if ({2'b0, fwd_sel4, stall4} !== {e.sel, e.st}) begin
                failures++;
                $display("FAIL sweep_adjacent step %0d: sel=%h stall=%b expected sel=%h stall=%b", j, fwd_sel4, stall4, e.sel, e.st);
            end
            @(posedge clk); #1;
        end
        do_reset();
        s.delete();
        s.push_back(mk(1, 5'd9,  1, 1, 5'd0, 5'd0, 2'b00, 0, 8'h00, 0));
        s.push_back(mk(1, 5'd12, 0, 0, 5'd0, 5'd0, 2'b00, 0, 8'h00, 0));
        s.push_back(mk(1, 5'd10, 0, 0, 5'd9, 5'd0, 2'b01, 0, 8'h02, 1));
        s.push_back(mk(1, 5'd10, 0, 0, 5'd9, 5'd0, 2'b01, 0, 8'h03, 0));
        s.push_back(mk(1, 5'd11, 0, 0, 5'd0, 5'd9, 2'b10, 0, 8'h20, 0));
        foreach (s[j]) begin
            apply(s[j]);
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if ({2'b0, fwd_sel4, stall4} !== {e.sel, e.st}) begin
                failures++;
                $display("FAIL sweep_gap step %0d: sel=%h stall=%b expected sel=%h stall=%b", j, fwd_sel4, stall4, e.sel, e.st);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        #1;
        test_reset();
        test_back_to_back();
        test_two_apart();
        test_load_use();
        test_youngest_x0();
        test_flush();
        test_reset_mid_stall();
        test_param_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
